// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory/write-back
// for a small MIPS-like ISA. It drives the datapath controls combinationally
// from the current state, the opcode and the ALU zero flag. It also counts
// retired instructions, which are the edges where the PC is written.
//
// Handshake: none. run=1 lets the FSM advance on each rising edge. run=0
// freezes the state and count and masks every write enable. Non-write selects
// stay visible so the datapath keeps a stable operand routing while frozen.
module mc_control_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [5:0]       decode,
    input  logic             zero,
    output logic             RegWre,
    output logic             PCWre,
    output logic             IRWre,
    output logic             ALUSrcB,
    output logic             ALUM2Reg,
    output logic             DataMemRw,
    output logic             ExtSel,
    output logic             InsMemRW,
    output logic             WrRegData,
    output logic [2:0]       ALUOp,
    output logic [1:0]       RegOut,
    output logic [1:0]       PCSrc,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_L   = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLT  = 6'b011000;
    localparam logic [5:0] OP_SW   = 6'b100110;
    localparam logic [5:0] OP_LW   = 6'b100111;
    localparam logic [5:0] OP_BEQ  = 6'b110000;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] REG_R31 = 2'b00;
    localparam logic [1:0] REG_RT  = 2'b01;
    localparam logic [1:0] REG_RD  = 2'b10;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_RS   = 2'b10;
    localparam logic [1:0] PC_JUMP = 2'b11;

    state_t     cur_state;
    state_t     nxt_state;
    logic       reg_wre_raw;
    logic       pc_wre_raw;
    logic       ir_wre_raw;
    logic       dmem_rw_raw;
    logic [2:0] al_op;
    logic       al_imm;

    // ALU operation and immediate-operand choice for arithmetic/logic opcodes
    always_comb begin
        al_imm = (decode == OP_ADDI) || (decode == OP_ORI);
        case (decode)
            OP_SUB:         al_op = ALU_SUB;
            OP_OR, OP_ORI:  al_op = ALU_OR;
            OP_AND:         al_op = ALU_AND;
            OP_SLT:         al_op = ALU_SLT;
            default:        al_op = ALU_ADD;
        endcase
    end

    // Next-state selection; unknown state codes recover to fetch
    always_comb begin
        nxt_state = S_IF;
        case (cur_state)
            S_IF: nxt_state = S_ID;
            S_ID: begin
                case (decode)
                    OP_ADD, OP_SUB, OP_ADDI, OP_OR,
                    OP_AND, OP_ORI, OP_SLT:  nxt_state = S_EXE_AL;
                    OP_BEQ:                  nxt_state = S_EXE_BR;
                    OP_LW, OP_SW:            nxt_state = S_EXE_LS;
                    OP_HALT:                 nxt_state = S_HALT;
                    default:                 nxt_state = S_IF;
                endcase
            end
            S_EXE_AL: nxt_state = S_WB_AL;
            S_WB_AL:  nxt_state = S_IF;
            S_EXE_BR: nxt_state = S_IF;
            S_EXE_LS: nxt_state = S_MEM;
            S_MEM:    nxt_state = (decode == OP_LW) ? S_WB_L : S_IF;
            S_WB_L:   nxt_state = S_IF;
            S_HALT:   nxt_state = S_HALT;
            default:  nxt_state = S_IF;
        endcase
    end

    // Datapath controls per state, before the run gating of write enables
    always_comb begin
        reg_wre_raw = 1'b0;
        pc_wre_raw  = 1'b0;
        ir_wre_raw  = 1'b0;
        dmem_rw_raw = 1'b0;
        ALUSrcB     = 1'b0;
        ALUM2Reg    = 1'b0;
        ExtSel      = 1'b0;
        WrRegData   = 1'b0;
        ALUOp       = ALU_ADD;
        RegOut      = REG_R31;
        PCSrc       = PC_SEQ;
        case (cur_state)
            S_IF: ir_wre_raw = 1'b1;
            S_ID: begin
                case (decode)
                    OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI,
                    OP_SLT, OP_BEQ, OP_LW, OP_SW, OP_HALT: ;
                    OP_J: begin
                        pc_wre_raw = 1'b1;
                        PCSrc      = PC_JUMP;
                    end
                    OP_JR: begin
                        pc_wre_raw = 1'b1;
                        PCSrc      = PC_RS;
                    end
                    OP_JAL: begin
                        pc_wre_raw  = 1'b1;
                        PCSrc       = PC_JUMP;
                        reg_wre_raw = 1'b1;
                        RegOut      = REG_R31;
                        WrRegData   = 1'b0;
                    end
                    default: begin
                        pc_wre_raw = 1'b1;
                        PCSrc      = PC_SEQ;
                    end
                endcase
            end
            S_EXE_AL, S_WB_AL: begin
                // write-back keeps the ALU routing so the result stays valid
                ALUOp   = al_op;
                ALUSrcB = al_imm;
                ExtSel  = (decode == OP_ADDI);
                if (cur_state == S_WB_AL) begin
                    reg_wre_raw = 1'b1;
                    WrRegData   = 1'b1;
                    pc_wre_raw  = 1'b1;
                    RegOut      = al_imm ? REG_RT : REG_RD;
                end
            end
            S_EXE_BR: begin
                ALUOp      = ALU_SUB;
                pc_wre_raw = 1'b1;
                PCSrc      = zero ? PC_BR : PC_SEQ;
                ExtSel     = 1'b1;
            end
            S_EXE_LS, S_MEM: begin
                ALUOp   = ALU_ADD;
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (cur_state == S_MEM) begin
                    if (decode == OP_SW) begin
                        dmem_rw_raw = 1'b1;
                        pc_wre_raw  = 1'b1;
                    end
                    if (decode == OP_LW) ALUM2Reg = 1'b1;
                end
            end
            S_WB_L: begin
                reg_wre_raw = 1'b1;
                RegOut      = REG_RT;
                WrRegData   = 1'b1;
                pc_wre_raw  = 1'b1;
            end
            default: ;
        endcase
    end

    // Write enables are masked while frozen; instruction memory is read-only
    always_comb begin
        RegWre    = reg_wre_raw & run;
        PCWre     = pc_wre_raw  & run;
        IRWre     = ir_wre_raw  & run;
        DataMemRw = dmem_rw_raw & run;
        InsMemRW  = 1'b1;
        state     = cur_state;
        halted    = (cur_state == S_HALT);
    end

    // State register and retired-instruction counter (a PC write retires one)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= S_IF;
            instr_count <= '0;
        end else if (run) begin
            cur_state <= nxt_state;
            if (PCWre) instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule
